// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus memory responder.
// Holds the handshake state encoding and the byte-lane merge rule.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCEPT
  } state_e;

  localparam int BYTE_LANES = 4;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // An all-zero enable is the CPU's legacy sw encoding and writes the whole word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [BYTE_LANES-1:0] be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be == '0 || be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_bus_memory_responder_if.sv
// mips_cpu_bus memory-side signal bundle; the CPU is the master, the RAM is the slave.
interface mips_bus_memory_responder_if;

  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        fault;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata, fault
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata, fault
  );

endinterface

// File: rtl/mips_bus_ram_array.sv
// Single-port word RAM with per-lane write mask and a registered read port.
// Contents are not reset; only the read register is.
module mips_bus_ram_array
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rdEn_i,
  input  logic                  rdZero_i,
  input  logic                  wrEn_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [BYTE_LANES-1:0] wmask_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[idx_i] <= merge_bytes(mem_q[idx_i], wdata_i, wmask_i);
    end
  end

  // Halt fetches and out-of-range reads load zero instead of a memory word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rdEn_i) begin
      rdata_q <= rdZero_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_bus_memory_responder.sv
// Bus responder: wait-state FSM, address decode and sticky fault around the RAM array.
// Word 0 sits at BASE_ADDR; address 0 is the CPU halt fetch and is silently absorbed.
module mips_bus_memory_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_bus_memory_responder_if.slave  bus
);

  localparam int IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        fault_q, fault_d;
  logic        request, accept, waitReq;
  logic [31:0] wordIdx;
  logic        isHalt, inRange;
  logic        doRead, doWrite;
  logic [31:0] rdata;

  assign request = bus.read | bus.write;
  assign wordIdx = (bus.address - BASE_ADDR) >> 2;
  assign isHalt  = (bus.address == '0);
  assign inRange = (wordIdx < 32'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // The presenting cycle counts as the first stall, so WAIT covers WAIT_CYCLES-1 more.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    if (WAIT_CYCLES == 0) begin
      state_d   = IDLE;
      waitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            waitCnt_d = 4'(WAIT_CYCLES - 1);
            state_d   = (WAIT_CYCLES == 1) ? ACCEPT : WAIT;
          end
        end
        WAIT: begin
          if (!request) begin
            state_d   = IDLE;
            waitCnt_d = '0;
          end else begin
            waitCnt_d = waitCnt_q - 4'd1;
            if (waitCnt_q <= 4'd1) begin
              state_d = ACCEPT;
            end
          end
        end
        ACCEPT: begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end
        default: begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    waitReq = 1'b0;
    accept  = 1'b0;
    if (WAIT_CYCLES == 0) begin
      accept = request;
    end else begin
      case (state_q)
        IDLE:    waitReq = request;
        WAIT:    waitReq = 1'b1;
        ACCEPT:  accept  = request;
        default: waitReq = 1'b0;
      endcase
    end
  end

  // A simultaneous read+write performs only the write and always flags fault.
  assign doRead  = accept & bus.read & ~bus.write;
  assign doWrite = accept & bus.write & inRange & ~isHalt;
  assign fault_d = fault_q | (accept & ((bus.read & bus.write) | (~isHalt & ~inRange)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  mips_bus_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) ramArray (
    .clk      (clk),
    .reset    (reset),
    .rdEn_i   (doRead),
    .rdZero_i (isHalt | ~inRange),
    .wrEn_i   (doWrite),
    .idx_i    (wordIdx[IdxW-1:0]),
    .wmask_i  (bus.byteenable),
    .wdata_i  (bus.writedata),
    .rdata_o  (rdata)
  );

  assign bus.waitrequest = waitReq;
  assign bus.readdata    = rdata;
  assign bus.fault       = fault_q;

endmodule
